// File: rtl/io_handshake_responder_pkg.sv
// Shared constants for the processor-side handshake responder.
package io_handshake_responder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/io_handshake_responder_if.sv
// Four-phase processor handshake bundle: the processor is master, the responder is slave.
interface io_handshake_responder_if import io_handshake_responder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             hs_out;
  logic             xfer_dir;
  logic [WIDTH-1:0] bus_out;
  logic             hs_in;
  logic [WIDTH-1:0] bus_in;

  modport master (output hs_out, xfer_dir, bus_out, input hs_in, bus_in);
  modport slave  (input hs_out, xfer_dir, bus_out, output hs_in, bus_in);
endinterface

// File: rtl/io_handshake_responder_sync_fifo.sv
// Single-clock FIFO. Overflowing pushes and underflowing pops are dropped.
// The head is read combinationally from storage.
module sync_fifo import io_handshake_responder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally at DEPTH; a push and a pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/io_handshake_responder.sv
// Responder side of a four-phase processor handshake. OUT transfers land in the
// RX FIFO for the host; IN transfers are served from the host-filled TX FIFO.
module io_handshake_responder import io_handshake_responder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  io_handshake_responder_if.slave  proc,
  input  logic                     tx_wr,
  input  logic [WIDTH-1:0]         tx_data,
  output logic                     tx_full,
  input  logic                     rx_rd,
  output logic [WIDTH-1:0]         rx_data,
  output logic                     rx_empty,
  output logic [7:0]               stall_cnt
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] bus_in_q;
  logic [WIDTH-1:0] tx_head;
  logic             tx_empty, rx_full;
  logic             tx_pop, rx_push, stall;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(g_clk), .clr(g_clr),
    .push(tx_wr), .din(tx_data), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(g_clk), .clr(g_clr),
    .push(rx_push), .din(proc.bus_out), .pop(rx_rd),
    .full(rx_full), .empty(rx_empty), .head(rx_data)
  );

  // Ack is a pure function of the registered state, so it rises one cycle after acceptance.
  assign proc.hs_in  = (state == ST_ACK);
  assign proc.bus_in = bus_in_q;

  // Next state plus the single FIFO side effect of an accepted request.
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (proc.hs_out) begin
          if (proc.xfer_dir ? !rx_full : !tx_empty) begin
            rx_push   = proc.xfer_dir;
            tx_pop    = !proc.xfer_dir;
            state_nxt = ST_ACK;
          end else begin
            stall = 1'b1;
          end
        end
      end
      ST_ACK:     if (!proc.hs_out) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, held read data and saturating stall counter.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state     <= ST_IDLE;
      bus_in_q  <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (tx_pop) bus_in_q <= tx_head;
      if (stall && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_io_handshake_responder.sv
// Directed scenarios plus randomized traffic against a queue-level model.
module tb_io_handshake_responder;
  localparam int W = 8;
  localparam int D = 4;

  logic         g_clk, g_clr;
  logic         tx_wr, rx_rd;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_full, rx_empty;
  logic [7:0]   stall_cnt;

  io_handshake_responder_if #(.WIDTH(W)) bus ();

  io_handshake_responder #(.WIDTH(W), .DEPTH(D)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .proc(bus),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .stall_cnt(stall_cnt)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queues plus a protocol phase (0 idle, 1 acked, 2 released).
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         phase;
  logic [7:0] m_bus_in;
  int         m_stall;

  initial begin
    phase = 0; m_bus_in = 8'h00; m_stall = 0;
    forever begin
      @(posedge g_clk);
      if (g_clr) begin
        txq.delete(); rxq.delete();
        phase = 0; m_bus_in = 8'h00; m_stall = 0;
      end else begin
        bit want, acc, txok, rxok;
        want = (phase == 0) && bus.hs_out;
        acc  = want && (bus.xfer_dir ? (rxq.size() < D) : (txq.size() > 0));
        txok = tx_wr && (txq.size() < D);
        rxok = rx_rd && (rxq.size() > 0);
        if (want && !acc && m_stall < 255) m_stall++;
        if (acc && !bus.xfer_dir) m_bus_in = txq.pop_front();
        if (txok) txq.push_back(tx_data);
        if (rxok) void'(rxq.pop_front());
        if (acc && bus.xfer_dir) rxq.push_back(bus.bus_out);
        if (acc) phase = 1;
        else if (phase == 1 && !bus.hs_out) phase = 2;
        else if (phase == 2) phase = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge g_clk);
      if (run_cmp) begin
        chk("hs_in", bus.hs_in, (phase == 1));
        chk("bus_in", bus.bus_in, m_bus_in);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("tx_full", tx_full, (txq.size() == D));
        chk("rx_empty", rx_empty, (rxq.size() == 0));
        if (rxq.size() > 0) chk("rx_data", rx_data, rxq[0]);
      end
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic host_push(input logic [7:0] v);
    tx_wr = 1'b1; tx_data = v;
    tick();
    tx_wr = 1'b0;
  endtask

  // Full four-phase transfer, with bounded waits on both ack edges.
  task automatic xfer(input logic d, input logic [7:0] v);
    int n;
    bus.hs_out = 1'b1; bus.xfer_dir = d; bus.bus_out = v;
    n = 0;
    do begin tick(); n++; end while (!bus.hs_in && n < 50);
    if (!bus.hs_in) chk("xfer_ack_timeout", 0, 1);
    bus.hs_out = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.hs_in && n < 50);
    if (bus.hs_in) chk("xfer_release_timeout", 1, 0);
    tick();
  endtask

  initial begin
    g_clr = 1'b1; tx_wr = 1'b0; rx_rd = 1'b0; tx_data = '0;
    bus.hs_out = 1'b0; bus.xfer_dir = 1'b0; bus.bus_out = '0;
    tick(); tick();
    g_clr = 1'b0;
    run_cmp = 1'b1;
    chk("rst_hs_in", bus.hs_in, 0);
    chk("rst_bus_in", bus.bus_in, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);

    // IN transfer served from the host TX push.
    host_push(8'hA5);
    bus.hs_out = 1'b1; bus.xfer_dir = 1'b0;
    tick();
    chk("in_ack_latency", bus.hs_in, 1);
    chk("in_bus_in", bus.bus_in, 8'hA5);
    bus.hs_out = 1'b0;
    tick();
    chk("in_release", bus.hs_in, 0);
    tick();
    chk("in_bus_in_held", bus.bus_in, 8'hA5);

    // OUT transfer lands in RX.
    bus.hs_out = 1'b1; bus.xfer_dir = 1'b1; bus.bus_out = 8'h3C;
    tick();
    chk("out_ack_latency", bus.hs_in, 1);
    chk("out_rx_empty", rx_empty, 0);
    chk("out_rx_data", rx_data, 8'h3C);
    bus.hs_out = 1'b0;
    tick(); tick();
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;

    // IN request stalls on empty TX; push during the fifth stalled cycle.
    bus.hs_out = 1'b1; bus.xfer_dir = 1'b0;
    repeat (4) tick();
    tx_wr = 1'b1; tx_data = 8'h11;
    tick();
    tx_wr = 1'b0;
    chk("stall_push_cycle_hs_in", bus.hs_in, 0);
    chk("stall_cnt_5", stall_cnt, 5);
    tick();
    chk("stall_then_ack", bus.hs_in, 1);
    chk("stall_bus_in", bus.bus_in, 8'h11);
    chk("stall_cnt_hold", stall_cnt, 5);
    bus.hs_out = 1'b0;
    tick(); tick();

    // Fill RX, fifth OUT request stalls until the host drains one byte.
    for (int i = 1; i <= 4; i++) xfer(1'b1, 8'(i));
    bus.hs_out = 1'b1; bus.xfer_dir = 1'b1; bus.bus_out = 8'h05;
    tick(); tick();
    chk("rx_full_stall", bus.hs_in, 0);
    chk("rx_full_stall_cnt", stall_cnt, 7);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    chk("rx_pop_cycle_still_stalled", bus.hs_in, 0);
    tick();
    chk("rx_fifth_accepted", bus.hs_in, 1);
    chk("rx_stall_cnt_8", stall_cnt, 8);
    bus.hs_out = 1'b0;
    tick(); tick();
    for (int v = 2; v <= 5; v++) begin
      chk("rx_order", rx_data, v);
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    end
    chk("rx_drained", rx_empty, 1);

    // Reset while acknowledging.
    xfer(1'b1, 8'h77);
    for (int i = 0; i < 4; i++) host_push(8'hAA + 8'(i));
    chk("tx_full_before_rst", tx_full, 1);
    bus.hs_out = 1'b1; bus.xfer_dir = 1'b0;
    tick();
    chk("ack_before_rst", bus.hs_in, 1);
    g_clr = 1'b1; bus.hs_out = 1'b0;
    tick();
    g_clr = 1'b0;
    chk("rst_mid_ack_hs_in", bus.hs_in, 0);
    chk("rst_mid_ack_stall", stall_cnt, 0);
    chk("rst_mid_ack_tx_full", tx_full, 0);
    chk("rst_mid_ack_rx_empty", rx_empty, 1);
    tick();

    // Ten bytes through TX across several pointer wraps.
    for (int i = 0; i < 3; i++) host_push(8'h40 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, 8'h00);
      chk("tx_wrap_order", bus.bus_in, 8'h40 + 8'(i));
      if (i + 3 < 10) host_push(8'h40 + 8'(i + 3));
    end

    // Stall counter saturation.
    bus.hs_out = 1'b1; bus.xfer_dir = 1'b0;
    repeat (260) tick();
    chk("stall_saturate", stall_cnt, 8'hFF);
    bus.hs_out = 1'b0;
    tick();

    // Randomized traffic: a loosely protocol-following processor and a busy host.
    for (int c = 0; c < 3000; c++) begin
      tx_wr   = ($urandom_range(0, 1) == 1);
      tx_data = 8'($urandom);
      rx_rd   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) begin
        g_clr = 1'b1; bus.hs_out = 1'b0;
      end else begin
        g_clr = 1'b0;
        if (!bus.hs_out && !bus.hs_in && $urandom_range(0, 2) == 0) begin
          bus.hs_out = 1'b1;
          bus.xfer_dir = 1'($urandom_range(0, 1));
          bus.bus_out = 8'($urandom);
        end else if (bus.hs_out && bus.hs_in && $urandom_range(0, 1) == 0) begin
          bus.hs_out = 1'b0;
        end else if (bus.hs_out && !bus.hs_in && $urandom_range(0, 29) == 0) begin
          bus.hs_out = 1'b0;
        end
      end
      tick();
    end
    g_clr = 1'b0; bus.hs_out = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_handshake_responder.md
IO_HANDSHAKE_RESPONDER -- requirements
Module: io_handshake_responder

Interface
REQ-001 Parameter WIDTH, default 8: byte width of bus_in/bus_out and both FIFOs.
REQ-002 Parameter DEPTH, default 4: entries per FIFO (power of two, >=2).
REQ-003 g_clk  input  1  single clock; all state updates on rising edge.
REQ-004 g_clr  input  1  reset, synchronous active-high.
REQ-005 hs_out  input  1  processor request strobe (four-phase req).
REQ-006 bus_out  input  WIDTH  processor output data, valid while hs_out high on OUT transfers.
REQ-007 xfer_dir  input  1  1 = processor OUT (write to responder), 0 = processor IN (read from responder); sampled only when a request is accepted.
REQ-008 hs_in  output  1  acknowledge to processor.
REQ-009 bus_in  output  WIDTH  data to processor RIN, registered.
REQ-010 tx_wr, tx_data  input  1, WIDTH  host push into TX FIFO (bytes destined for processor).
REQ-011 tx_full  output  1  TX FIFO full.
REQ-012 rx_rd  input  1  host pop from RX FIFO; rx_data output WIDTH = RX head (combinational from storage).
REQ-013 rx_empty  output  1  RX FIFO empty.
REQ-014 stall_cnt  output  8  saturating count of cycles a request is held off by full/empty FIFO.

Function
REQ-015 FSM states IDLE, ACK, RELEASE; one-hot not required.
REQ-016 IDLE, hs_out=1, xfer_dir=1, RX not full: push bus_out into RX, hs_in=1 next cycle, go ACK.
REQ-017 IDLE, hs_out=1, xfer_dir=0, TX not empty: pop TX head into bus_in register, hs_in=1 next cycle, go ACK.
REQ-018 IDLE, hs_out=1, required FIFO blocked: remain IDLE, hs_in=0, stall_cnt += 1 (saturate at 255).
REQ-019 ACK: hold hs_in=1 and bus_in stable until hs_out sampled 0; then go RELEASE.
REQ-020 RELEASE: hs_in=0; return to IDLE next cycle; a new request is never accepted in RELEASE (minimum one idle cycle between transfers).
REQ-021 Exactly one FIFO push or pop per accepted transfer; none while in ACK or RELEASE.
REQ-022 Request-to-ack latency: exactly 1 cycle when unblocked.
REQ-023 bus_in retains its last value between transfers.
REQ-024 Host tx_wr when full is ignored; rx_rd when empty is ignored; no pointer change.
REQ-025 Simultaneous host tx_wr and protocol TX pop in the same cycle both take effect; occupancy unchanged. Same for rx_rd with RX push.
REQ-026 When TX is empty, a host push and a protocol request in the same cycle: request stalls that cycle; it is accepted on the next cycle.
REQ-027 Pointers are log2(DEPTH) bits with wrap-around; occupancy counters are log2(DEPTH)+1 bits.

Reset
REQ-028 g_clr high at a clock edge: state=IDLE, hs_in=0, bus_in=0, both FIFOs empty, stall_cnt=0, regardless of transfer in progress.
REQ-029 Reset mid-ACK drops hs_in the cycle after the edge; the partially handshaken byte is discarded.

Structure
REQ-030 State encoding constants and default WIDTH/DEPTH live in the shared processor package.
REQ-031 Both FIFOs are instances of one sub-module sync_fifo (WIDTH, DEPTH; push, pop, full, empty, head).
REQ-032 FSM and stall counter live in the top module.

Verification
REQ-033 Host pushes 8'hA5; processor hs_out=1, xfer_dir=0 -> next cycle hs_in=1, bus_in=8'hA5; hs_out=0 -> hs_in=0 after RELEASE.
REQ-034 Processor OUT 8'h3C with xfer_dir=1 -> hs_in=1 after 1 cycle, rx_empty=0, rx_data=8'h3C.
REQ-035 TX empty, hs_out=1, xfer_dir=0 for 5 cycles, then host pushes 8'h11 -> stall_cnt=5, ack on the cycle after the push, bus_in=8'h11.
REQ-036 Fill RX with 4 OUT transfers (01..04); fifth request stalls; rx_rd once -> fifth accepted; pops read 02,03,04,05 in order.
REQ-037 g_clr asserted while in ACK -> hs_in=0, stall_cnt=0, tx_full=0, rx_empty=1 next cycle.
REQ-038 Push/pop 10 bytes through TX with interleaved transfers -> order preserved across pointer wrap.
